softmax_normalizer_seq: RTL and testbench

- Sequencing datapath that drives the external reciprocal_pwl unit and consumes its result to complete the pseudo-softmax.
- Buffers a streamed vector of 8-bit logits and finds the maximum.
- Computes a PWL 2^-d term per element and sums the terms.
- Sends the normalized sum to reciprocal_pwl, then streams out y_i ≈ 256·e_i/Σe as a Q0.8 probability vector.

---
 rtl/softmax_pkg.sv | 34 +++
 rtl/softmax_normalizer_pow2.sv | 23 ++
 rtl/softmax_normalizer_seq.sv | 168 ++++++++++++++++
 tb/tb_softmax_normalizer_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared definitions for the pseudo-softmax normalizer.
// Holds the sequencer state encoding, default sizing, Q-format widths and
// the MSB-index helper used to normalize the exponent sum.
package softmax_pkg;

  localparam int MAX_N_DEF     = 16;
  localparam int SUM_W_DEF     = 12;
  localparam int RECIP_LAT_DEF = 1;

  // Logits are Q4.4, probabilities Q0.8, both one byte wide.
  localparam int DATA_W    = 8;
  localparam int LOGIT_FRAC = 4;
  localparam int PROB_W    = 8;

  // reciprocal_pwl contract: min(255, floor(RECIP_NUM / recip_in)).
  localparam int RECIP_NUM = 32768;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXP,
    S_NORM,
    S_WAIT,
    S_EMIT
  } state_t;

  // Index of the highest set bit; 0 when v is 0.
  function automatic logic [4:0] msb_idx(input logic [31:0] v);
    msb_idx = '0;
    for (int i = 0; i < 32; i++)
      if (v[i]) msb_idx = i[4:0];
  endfunction

endpackage

// File: rtl/softmax_normalizer_pow2.sv
// pow2_pwl: combinational piecewise-linear 2^-d.
//   d : Q4.4 distance below the vector maximum (unsigned)
//   e : 255 * 2^-d approximation; integer part shifts, fraction bends a line
// Ports: d in 8, e out 8.
module pow2_pwl
  import softmax_pkg::*;
(
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] e
);

  logic [3:0]        k;
  logic [3:0]        f;
  logic [DATA_W-1:0] m;

  assign k = d[7:4];
  assign f = d[3:0];
  // Linear segment from 255 down to 135 across one octave; shift by k
  // selects the octave (k>=8 collapses to 0).
  assign m = 8'd255 - {1'b0, f, 3'b000};
  assign e = m >> k;

endmodule

// File: rtl/softmax_normalizer_seq.sv
// softmax_normalizer_seq: buffers a logit vector, forms PWL exponent terms
// relative to the vector max, normalizes the sum for an external
// reciprocal_pwl unit, then streams Q0.8 probabilities.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_data/in_last   logit stream (Q4.4), in_ready back-pressure
//   recip_in / recip_out       normalized sum out, reciprocal back
//   out_valid/out_data/out_last probability stream (Q0.8), out_ready in
//   trunc                      sticky: a vector overran MAX_N
module softmax_normalizer_seq
  import softmax_pkg::*;
#(
  parameter int MAX_N     = MAX_N_DEF,
  parameter int RECIP_LAT = RECIP_LAT_DEF,
  parameter int SUM_W     = SUM_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] recip_in,
  input  logic [DATA_W-1:0] recip_out,
  output logic              out_valid,
  output logic [PROB_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              trunc
);

  localparam int CNT_W = $clog2(MAX_N + 1);
  localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int LAT_W = (RECIP_LAT > 1) ? $clog2(RECIP_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(MAX_N - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RECIP_LAT - 1);

  state_t state, state_nxt;

  logic [CNT_W-1:0]    cnt, idx, last_idx;
  logic [DATA_W-1:0]   mx, r;
  logic [DATA_W-1:0]   rd_val, d_val, e_val, norm8;
  logic [SUM_W-1:0]    sum;
  logic [4:0]          p, msb, sh;
  logic [LAT_W-1:0]    wcnt;
  logic [DATA_W-1:0]   mem [MAX_N];
  logic                hs_in, hs_out, at_cap, take_last, at_end, wait_done;
  logic [2*DATA_W-1:0] prod, scaled;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      S_IDLE, S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = take_last ? S_EXP : S_LOAD;
      end
      S_EXP:  if (at_end) state_nxt = S_NORM;
      S_NORM: state_nxt = S_WAIT;
      S_WAIT: if (wait_done) state_nxt = S_EMIT;
      S_EMIT: begin
        out_valid = 1'b1;
        out_last  = at_end;
        if (out_ready && at_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  assign last_idx  = cnt - CNT_ONE;
  assign at_end    = (idx == last_idx);
  assign at_cap    = (cnt == CNT_CAP);
  // The MAX_N-th element closes the vector even without in_last.
  assign take_last = in_last | at_cap;
  assign wait_done = (wcnt == LAT_LAST);
  assign hs_in     = in_valid & in_ready;
  assign hs_out    = out_valid & out_ready;

  assign rd_val = mem[idx[IDX_W-1:0]];
  assign d_val  = mx - rd_val;

  pow2_pwl u_pow2 (
    .d (d_val),
    .e (e_val)
  );

  // Bring the sum into [128,255]; the max element contributes 255, so the
  // MSB is always at bit 7 or above.
  assign msb   = msb_idx(32'(sum));
  assign sh    = (msb > 5'd7) ? (msb - 5'd7) : 5'd0;
  assign norm8 = DATA_W'(sum >> sh);

  // y = e * r / 2^p, saturated to one byte. Held by idx/r/p while stalled.
  assign prod   = {8'd0, rd_val} * {8'd0, r};
  assign scaled = prod >> p;
  assign out_data = (state == S_EMIT)
                  ? ((scaled > 16'd255) ? 8'hFF : scaled[7:0])
                  : '0;

  // Buffer holds logits during load, exponent terms from EXP onward.
  always_ff @(posedge clk) begin
    if (hs_in)               mem[cnt[IDX_W-1:0]] <= in_data;
    else if (state == S_EXP) mem[idx[IDX_W-1:0]] <= e_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      mx       <= '0;
      sum      <= '0;
      p        <= '0;
      r        <= '0;
      wcnt     <= '0;
      recip_in <= '0;
      trunc    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_LOAD: if (hs_in) begin
          cnt <= cnt + CNT_ONE;
          idx <= '0;
          if (state == S_IDLE) begin
            mx  <= in_data;
            sum <= '0;
          end else if (in_data > mx) begin
            mx <= in_data;
          end
          if (at_cap && !in_last) trunc <= 1'b1;
        end
        S_EXP: begin
          sum <= sum + SUM_W'(e_val);
          idx <= at_end ? '0 : idx + CNT_ONE;
        end
        S_NORM: begin
          p        <= msb;
          recip_in <= norm8;
          wcnt     <= '0;
        end
        S_WAIT: begin
          wcnt <= wcnt + LAT_W'(1);
          if (wait_done) r <= recip_out;
        end
        S_EMIT: if (hs_out) begin
          if (at_end) begin
            cnt      <= '0;
            idx      <= '0;
            mx       <= '0;
            sum      <= '0;
            recip_in <= '0;
          end else begin
            idx <= idx + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_normalizer_seq.sv
// Self-checking bench for softmax_normalizer_seq: directed vector table,
// hand-written backpressure and mid-run reset sequences, and random vectors
// against an arithmetic reference model. reciprocal_pwl is modelled here.
module tb_softmax_normalizer_seq;

  localparam int MAX_N     = 16;
  localparam int RECIP_LAT = 1;
  localparam int SUM_W     = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last, in_ready;
  logic [7:0] in_data;
  logic [7:0] recip_in, recip_out;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic       trunc;
  logic [15:0] q;

  always #5 clk = ~clk;

  softmax_normalizer_seq #(
    .MAX_N(MAX_N), .RECIP_LAT(RECIP_LAT), .SUM_W(SUM_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .recip_in(recip_in), .recip_out(recip_out),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .trunc(trunc)
  );

  // reciprocal_pwl model: result valid the cycle after recip_in registers.
  always_comb begin
    q = 16'h0;
    recip_out = 8'hFF;
    if (recip_in != 8'd0) begin
      q = 16'h8000 / {8'd0, recip_in};
      recip_out = (q > 16'd255) ? 8'hFF : q[7:0];
    end
  end

  typedef struct packed {
    logic [4:0]        n;
    logic              has_last;
    logic [16:0][7:0]  x;
    logic [15:0][7:0]  y;
    logic [7:0]        rin;
    logic              trunc_exp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int xs[$];
  int exp_y[$];
  int exp_rin;
  bit exp_trunc;
  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: e_i = 255*2^-d by octave and 1/8-slope fraction, normalize
  // the sum to 8 bits, reciprocal by contract, scale back by 2^p.
  function automatic void run_model(input int n);
    int mx, sum, p, r, d, y;
    int e[16];
    mx = 0;
    for (int i = 0; i < n; i++) if (xs[i] > mx) mx = xs[i];
    sum = 0;
    for (int i = 0; i < n; i++) begin
      d = mx - xs[i];
      e[i] = (255 - 8 * (d % 16)) / (2 ** (d / 16));
      sum += e[i];
    end
    p = 0;
    while ((1 << (p + 1)) <= sum) p++;
    exp_rin = sum >> (p - 7);
    r = 32768 / exp_rin;
    if (r > 255) r = 255;
    exp_y.delete();
    for (int i = 0; i < n; i++) begin
      y = (e[i] * r) >> p;
      if (y > 255) y = 255;
      exp_y.push_back(y);
    end
  endfunction

  task automatic send(input int n, input bit use_last);
    int w;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(xs[i]);
      in_last  = use_last && (i == n - 1);
      w = 0;
      while (!in_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (w >= 100) chk("in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits for the first probability, checks latency, then drains nacc
  // outputs. probe offers an extra logit while the block is busy.
  task automatic recv(input int nacc, input bit stall_first, input bit rnd, input bit probe);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (probe && k == 1) begin
        in_valid = 1'b1;
        in_data  = 8'h00;
        in_last  = 1'b0;
      end
      if (probe && k == 3) in_valid = 1'b0;
      if (k <= 2) chk("in_ready_busy", int'(in_ready), 0);
    end while (!out_valid && k < 300);
    chk("latency", k, nacc + 2 + RECIP_LAT);
    chk("recip_in", int'(recip_in), exp_rin);
    chk("trunc", int'(trunc), int'(exp_trunc));
    for (int j = 0; j < nacc; j++) begin
      if (stall_first && j == 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_data", int'(out_data), exp_y[0]);
          @(negedge clk);
        end
      end else if (rnd) begin
        out_ready = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      out_ready = 1'b1;
      chk("out_valid", int'(out_valid), 1);
      chk("out_data", int'(out_data), exp_y[j]);
      chk("out_last", int'(out_last), (j == nacc - 1) ? 1 : 0);
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
    end
    chk("idle_valid", int'(out_valid), 0);
    chk("idle_ready", int'(in_ready), 1);
  endtask

  task automatic run_vec(input vec_t v);
    int nacc;
    xs.delete();
    for (int i = 0; i < int'(v.n); i++) xs.push_back(int'(v.x[i]));
    nacc = (int'(v.n) > MAX_N) ? MAX_N : int'(v.n);
    send(nacc, v.has_last);
    exp_y.delete();
    for (int i = 0; i < nacc; i++) exp_y.push_back(int'(v.y[i]));
    exp_rin   = int'(v.rin);
    exp_trunc = v.trunc_exp;
    recv(nacc, 1'b0, 1'b0, int'(v.n) > MAX_N);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    bit lst;
    int base, spread;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_recip_in", int'(recip_in), 0);
    chk("rst_trunc", int'(trunc), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) tbl[i] = '0;
    tbl[0].n = 1; tbl[0].has_last = 1; tbl[0].x[0] = 8'h37;
    tbl[0].y[0] = 255; tbl[0].rin = 255;
    tbl[1].n = 2; tbl[1].has_last = 1; tbl[1].x[0] = 8'h10; tbl[1].x[1] = 8'h00;
    tbl[1].y[0] = 170; tbl[1].y[1] = 84; tbl[1].rin = 191;
    tbl[2].n = 2; tbl[2].has_last = 1; tbl[2].x[0] = 8'h20; tbl[2].x[1] = 8'h20;
    tbl[2].y[0] = 127; tbl[2].y[1] = 127; tbl[2].rin = 255;
    // Full-length vector closed by in_last on the 16th: not a truncation.
    tbl[3].n = 16; tbl[3].has_last = 1; tbl[3].rin = 255;
    for (int i = 0; i < 16; i++) tbl[3].y[i] = 15;
    // 17 logits, no in_last: 16 kept, trunc sticks.
    tbl[4].n = 17; tbl[4].has_last = 0; tbl[4].rin = 255; tbl[4].trunc_exp = 1;
    for (int i = 0; i < 16; i++) tbl[4].y[i] = 15;

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // Output backpressure on the first probability.
    xs = {16, 0};
    send(2, 1'b1);
    exp_y = {170, 84};
    exp_rin = 191;
    recv(2, 1'b1, 1'b0, 1'b0);

    // Random vectors against the reference model.
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 16);
      lst = !(n == 16 && ($urandom % 2 == 1));
      base = $urandom_range(0, 255);
      case ($urandom % 3)
        0: spread = 16;
        1: spread = 64;
        default: spread = 256;
      endcase
      xs.delete();
      for (int i = 0; i < n; i++) xs.push_back((base + $urandom_range(0, spread - 1)) % 256);
      send(n, lst);
      if (!lst) exp_trunc = 1'b1;
      run_model(n);
      recv(n, 1'b0, 1'b1, 1'b0);
    end

    // Reset pulsed during EXP of a 4-element vector.
    xs.delete();
    for (int i = 0; i < 4; i++) xs.push_back($urandom_range(0, 255));
    send(4, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_data", int'(out_data), 0);
    chk("mid_rst_out_last", int'(out_last), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_recip_in", int'(recip_in), 0);
    chk("mid_rst_trunc", int'(trunc), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_trunc = 1'b0;
    xs = {0};
    send(1, 1'b1);
    exp_y = {255};
    exp_rin = 255;
    recv(1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
